matmul_mem_bridge: RTL and testbench

//  Memory-side neighbour of the matmul engine. Serves the engine's per-cycle

---
 rtl/matmul_mem_bridge_pkg.sv | 11 +
 rtl/matmul_mem_bridge_if.sv | 36 +++
 rtl/matmul_mem_bridge_rsp_pipe.sv | 45 ++++
 rtl/matmul_mem_bridge.sv | 68 ++++++
 tb/tb_matmul_mem_bridge.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/matmul_mem_bridge_pkg.sv
// matmul_mem_bridge_pkg: shared owner encoding, tag type and bus width defaults
package matmul_pkg;
  localparam int MEM_AW_DFLT = 16;
  localparam int MEM_DW_DFLT = 32;
  localparam logic OWN_ENG = 1'b0;
  localparam logic OWN_HOST = 1'b1;
  typedef struct packed {
    logic vld;
    logic owner;
  } tag_t;
endpackage

// File: rtl/matmul_mem_bridge_if.sv
// matmul_mem_bridge_if: engine, host and SRAM buses of the memory bridge
interface matmul_mem_bridge_if #(
  parameter int AW = matmul_pkg::MEM_AW_DFLT,
  parameter int DW = matmul_pkg::MEM_DW_DFLT
);
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdata_vld;
  logic [DW-1:0] mem_rdata;
  logic          host_req;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rdata_vld;
  logic [DW-1:0] host_rdata;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    input  host_req, host_write, host_addr, host_wdata, sram_rdata,
    output mem_rdata_vld, mem_rdata, host_gnt, host_rdata_vld, host_rdata,
    output sram_ce, sram_we, sram_addr, sram_wdata
  );
  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    output host_req, host_write, host_addr, host_wdata, sram_rdata,
    input  mem_rdata_vld, mem_rdata, host_gnt, host_rdata_vld, host_rdata,
    input  sram_ce, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/matmul_mem_bridge_rsp_pipe.sv
// matmul_rsp_pipe: RD_LAT+1 deep {vld,owner} tag pipe and per-owner read-data demux
module matmul_rsp_pipe
  import matmul_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DW     = MEM_DW_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  tag_t          push_i,
  input  logic [DW-1:0] rdata_i,
  output logic          mem_vld_o,
  output logic [DW-1:0] mem_rdata_o,
  output logic          host_vld_o,
  output logic [DW-1:0] host_rdata_o
);
  tag_t [RD_LAT:0] tags_q;
  tag_t            tail;
  logic            mem_hit, host_hit;
  logic            mem_vld_q, host_vld_q;
  logic [DW-1:0]   mem_rdata_q, host_rdata_q;
  // the tail lines up with sram_rdata of the command issued RD_LAT cycles ago
  assign tail     = tags_q[RD_LAT];
  assign mem_hit  = tail.vld & (tail.owner == OWN_ENG);
  assign host_hit = tail.vld & (tail.owner == OWN_HOST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q       <= '0;
      mem_vld_q    <= 1'b0;
      host_vld_q   <= 1'b0;
      mem_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      tags_q     <= {tags_q[RD_LAT-1:0], push_i};
      mem_vld_q  <= mem_hit;
      host_vld_q <= host_hit;
      if (mem_hit) mem_rdata_q <= rdata_i;
      if (host_hit) host_rdata_q <= rdata_i;
    end
  end
  assign mem_vld_o    = mem_vld_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign host_vld_o   = host_vld_q;
  assign host_rdata_o = host_rdata_q;
endmodule

// File: rtl/matmul_mem_bridge.sv
// matmul_mem_bridge: engine-first arbiter onto one SRAM, command register,
// host stall counter and in-order read response routing
module matmul_mem_bridge
  import matmul_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DFLT,
  parameter int MEM_DW = MEM_DW_DFLT,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  matmul_mem_bridge_if.slave bus,
  input  logic             stall_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o
);
  logic              acc, wr;
  logic [MEM_AW-1:0] addr;
  logic [MEM_DW-1:0] wdata;
  tag_t              push;
  logic              ce_q, we_q;
  logic [MEM_AW-1:0] addr_q;
  logic [MEM_DW-1:0] wdata_q;
  logic [CNT_W-1:0]  stall_q, stall_d;
  assign bus.host_gnt = bus.host_req & ~bus.mem_req;
  always_comb begin
    acc     = bus.mem_req | bus.host_gnt;
    wr      = bus.mem_req ? bus.mem_write : bus.host_write;
    addr    = bus.mem_req ? bus.mem_addr  : bus.host_addr;
    wdata   = bus.mem_req ? bus.mem_wdata : bus.host_wdata;
    push    = '{vld: acc & ~wr, owner: bus.mem_req ? OWN_ENG : OWN_HOST};
    stall_d = stall_clr_i ? '0 :
              (bus.host_req & bus.mem_req & ~&stall_q) ? stall_q + 1'b1 : stall_q;
  end
  // address/data hold their last value while idle; only ce drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      stall_q <= '0;
    end else begin
      ce_q    <= acc;
      stall_q <= stall_d;
      if (acc) begin
        we_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end
  assign bus.sram_ce    = ce_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign stall_cnt_o    = stall_q;
  matmul_rsp_pipe #(.RD_LAT(RD_LAT), .DW(MEM_DW)) u_rsp (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .rdata_i     (bus.sram_rdata),
    .mem_vld_o   (bus.mem_rdata_vld),
    .mem_rdata_o (bus.mem_rdata),
    .host_vld_o  (bus.host_rdata_vld),
    .host_rdata_o(bus.host_rdata)
  );
endmodule

// File: tb/tb_matmul_mem_bridge.sv
// tb_matmul_mem_bridge: scoreboard bench with an SRAM model and a transaction-level reference
module tb_matmul_mem_bridge;
  import matmul_pkg::*;
  localparam int AW = 16, DW = 32, RD_LAT = 3, CNT_W = 4;
  localparam int SMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, stall_clr = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  always #5 clk = ~clk;
  matmul_mem_bridge_if #(.AW(AW), .DW(DW)) bus();
  matmul_mem_bridge #(.MEM_AW(AW), .MEM_DW(DW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall_clr_i(stall_clr), .stall_cnt_o(stall_cnt)
  );
  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  logic [DW-1:0] sram [int];
  logic [DW-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    rpipe[0] <= (bus.sram_ce && !bus.sram_we) ?
                (sram.exists(int'(bus.sram_addr)) ? sram[int'(bus.sram_addr)] : init_val(int'(bus.sram_addr))) :
                32'hBAADF00D;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    if (bus.sram_ce && bus.sram_we) sram[int'(bus.sram_addr)] = bus.sram_wdata;
  end
  assign bus.sram_rdata = rpipe[RD_LAT-1];
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
  endfunction
  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic          exp_ce = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wd = '0;
  int            exp_stall = 0;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_mem_vld", 32'(bus.mem_rdata_vld), 0);
      chk("rst_host_vld", 32'(bus.host_rdata_vld), 0);
      chk("rst_mem_rdata", bus.mem_rdata, 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
      chk("rst_sram_ce", 32'(bus.sram_ce), 0);
      chk("rst_sram_addr", 32'(bus.sram_addr), 0);
      chk("rst_sram_wdata", bus.sram_wdata, 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
    end else begin
      chk("one_vld", 32'(bus.mem_rdata_vld & bus.host_rdata_vld), 0);
      chk("host_gnt", 32'(bus.host_gnt), 32'(bus.host_req & ~bus.mem_req));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      chk("sram_ce", 32'(bus.sram_ce), 32'(exp_ce));
      if (exp_ce) begin
        chk("sram_we", 32'(bus.sram_we), 32'(exp_we));
        chk("sram_addr", 32'(bus.sram_addr), 32'(exp_addr));
        if (exp_we) chk("sram_wdata", bus.sram_wdata, exp_wd);
      end
      if (bus.mem_rdata_vld || bus.host_rdata_vld) begin
        if (q.size() == 0) chk("unexpected_vld", 32'({bus.mem_rdata_vld, bus.host_rdata_vld}), 0);
        else begin
          e = q.pop_front();
          chk("rsp_owner", 32'(bus.host_rdata_vld), 32'(e.owner));
          chk("rsp_data", e.owner ? bus.host_rdata : bus.mem_rdata, e.data);
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() != 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("rsp_missing", 32'(bus.mem_rdata_vld | bus.host_rdata_vld), 1);
      end
    end
  end
  // one cycle of stimulus; the engine's request is served if present, else a waiting host's
  task automatic step(input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                      input logic clr, output logic hg);
    logic n_ce, n_we;
    logic [AW-1:0] n_a;
    logic [DW-1:0] n_d;
    int n_s;
    bus.mem_req = er; bus.mem_write = ew; bus.mem_addr = ea; bus.mem_wdata = ed;
    bus.host_req = hr; bus.host_write = hw; bus.host_addr = ha; bus.host_wdata = hd;
    stall_clr = clr;
    hg = hr & ~er;
    n_ce = er | hg;
    n_we = er ? ew : hw;
    n_a  = er ? ea : ha;
    n_d  = er ? ed : hd;
    if (n_ce) begin
      if (n_we) ref_mem[int'(n_a)] = n_d;
      else q.push_back('{owner: er ? OWN_ENG : OWN_HOST, data: ref_rd(n_a), due: cyc + RD_LAT + 2});
    end
    n_s = clr ? 0 : (hr && er) ? ((exp_stall < SMAX) ? exp_stall + 1 : SMAX) : exp_stall;
    @(posedge clk); #1;
    exp_ce = n_ce;
    if (n_ce) begin exp_we = n_we; exp_addr = n_a; exp_wd = n_d; end
    exp_stall = n_s;
  endtask
  task automatic idle(input int n);
    logic g;
    repeat (n) step(0, 0, '0, '0, 0, 0, '0, '0, 0, g);
  endtask
  task automatic host_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic g;
    step(0, 0, '0, '0, 1, w, a, d, 0, g);
  endtask
  task automatic eng_rd(input logic [AW-1:0] a);
    logic g;
    step(1, 0, a, '0, 0, 0, '0, '0, 0, g);
  endtask
  initial begin
    logic g, hp, hw;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    bus.mem_req = 0; bus.mem_write = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.host_req = 0; bus.host_write = 0; bus.host_addr = '0; bus.host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    host_op(1, 16'h10, 5);
    host_op(1, 16'h11, 7);
    eng_rd(16'h10);
    eng_rd(16'h11);
    idle(RD_LAT + 3);
    step(0, 0, '0, '0, 0, 0, '0, '0, 1, g);
    repeat (4) step(1, 0, AW'($urandom_range(15)), '0, 1, 1, 16'h20, 32'hDEAD, 0, g);
    step(0, 0, '0, '0, 1, 1, 16'h20, 32'hDEAD, 0, g);
    eng_rd(16'h20);
    idle(RD_LAT + 3);
    host_op(1, 16'h1, 32'hA);
    host_op(1, 16'h2, 32'hB);
    repeat (4) begin
      eng_rd(16'h1);
      host_op(0, 16'h2, '0);
    end
    idle(RD_LAT + 3);
    host_op(1, 16'h30, 32'h1234);
    eng_rd(16'h30);
    idle(RD_LAT + 3);
    eng_rd(16'h10);
    eng_rd(16'h11);
    rst_n = 1'b0;
    q.delete();
    exp_ce = 0; exp_we = 0; exp_stall = 0;
    bus.mem_req = 0; bus.host_req = 0; stall_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(RD_LAT + 4);
    repeat (SMAX + 4) step(1, 0, AW'($urandom_range(31)), '0, 1, 0, 16'h40, '0, 0, g);
    step(1, 0, AW'($urandom_range(31)), '0, 1, 0, 16'h40, '0, 1, g);
    step(0, 0, '0, '0, 1, 0, 16'h40, '0, 0, g);
    idle(RD_LAT + 3);
    hp = 0; hw = 0; ha = '0; hd = '0;
    repeat (3000) begin
      if (!hp && $urandom_range(2) == 0) begin
        hp = 1;
        hw = 1'($urandom_range(1));
        ha = AW'($urandom_range(31));
        hd = $urandom;
      end
      step(1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom_range(31)), $urandom,
           hp, hw, ha, hd, $urandom_range(15) == 0, g);
      if (g) hp = 0;
    end
    idle(RD_LAT + 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
